wb_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single Wishbone slave bus of the RISC-V SoC between several masters (instruction fetch, data port, cache refill). It sits between the master ports and the address decoder feeding PIO, SPI, UART and main memory. The grant is held for a whole bus cycle (CYC). An optional watchdog terminates stalled transfers with ERR.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/wb_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and defaults for the Wishbone round-robin arbiter.
//   arb_state_e        : arbiter FSM states (IDLE / BUSY / ABORT)
//   DEF_NUM_MASTERS    : default number of requesting masters
//   DEF_ADDR_WIDTH     : default Wishbone address width
//   DEF_DATA_WIDTH     : default Wishbone data width
//   DEF_TIMEOUT_CYCLES : default watchdog limit (used with WB_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_MASTERS    = 2;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. Scans the request vector starting at
// the index after the last grant, wrapping around, and returns the first hit.
//   req_i     [N-1:0]  request vector
//   last_i    [IW-1:0] index of the previous grant
//   gnt_o     [N-1:0]  one-hot grant (0 when no request)
//   gnt_idx_o [IW-1:0] index of the grant
//   valid_o            at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = '0;
    // Offset 1..N visits every master once, the last grant being lowest priority.
    for (int unsigned off = 1; off <= N; off++) begin
      idx = IW'((32'(last_i) + off) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter sharing one Wishbone slave bus between NUM_MASTERS
// masters. The grant is held for the whole CYC of the granted master; one
// dead IDLE cycle separates tenures.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to terminate stalled transfers
// with a one-cycle ERR after TIMEOUT_CYCLES unanswered strobe cycles.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   m_cyc/stb/we_i        per-master controls
//   m_adr/dat/sel_i       packed per-master address/write data/byte selects
//   m_dat_o               read data broadcast to all masters
//   m_ack_o, m_err_o      responses routed to the granted master only
//   s_*_o / s_*_i         slave-side bus
//   grant_o               one-hot current grant, 0 when idle
// -----------------------------------------------------------------------------
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
`ifdef WB_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned IW = $clog2(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  logic                   own_cyc, own_stb, own_we, busy;
  logic [ADDR_WIDTH-1:0]  adr_mux;
  logic [DATA_WIDTH-1:0]  dat_mux;
  logic [SW-1:0]          sel_mux;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i     (m_cyc_i),
    .last_i    (last_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  // Granted-master bus mux (grant_q is one-hot or zero).
  always_comb begin
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        adr_mux |= m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        dat_mux |= m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_mux |= m_sel_i[i*SW +: SW];
      end
    end
  end

  assign own_cyc = |(m_cyc_i & grant_q);
  assign own_stb = |(m_stb_i & grant_q);
  assign own_we  = |(m_we_i  & grant_q);
  assign busy    = (state_q == ST_BUSY);

  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = busy & own_stb;
  assign s_we_o  = busy & own_we;
  assign s_adr_o = busy ? adr_mux : '0;
  assign s_dat_o = busy ? dat_mux : '0;
  assign s_sel_o = busy ? sel_mux : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;

  // Fires on the stall cycle that would bring the count to the limit; a
  // response in that same cycle suppresses it.
  assign timeout_hit = busy & own_cyc & s_stb_o & ~s_ack_i & ~s_err_i &
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE || s_ack_i || s_err_i) begin
      cnt_d = '0;
    end else if (busy && s_stb_o && !timeout_hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          last_d  = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // ERR wins over ACK when both arrive together.
        m_ack_o = grant_q & {NUM_MASTERS{s_ack_i & ~s_err_i}};
        m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
        if (!own_cyc) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          m_err_o = grant_q;
          state_d = ST_ABORT;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!own_cyc) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Directed self-checking bench for wb_rr_arbiter with two masters.
// Inputs change 1 ns after the rising edge; outputs are checked 3 ns after it.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [NM-1:0] exp_g;
  logic [AW-1:0] exp_a;

  always #5 CLK = ~CLK;

  wb_rr_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .grant_o (grant_o)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST     = 1'b1;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_s_stb", 64'(s_stb_o), 64'h0);
    chk("rst_ack",   64'(m_ack_o), 64'h0);
    chk("rst_err",   64'(m_err_o), 64'h0);

    // Single write from master 0
    tick();
    RST     = 1'b0;
    m_adr_i = {32'h0000_1000, 32'h8000_0000};
    m_dat_i = {32'hAAAA_0000, 32'h0000_0055};
    m_sel_i = {4'h3, 4'hF};
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    m_we_i  = 2'b01;
    settle();
    chk("wr_pre_cyc", 64'(s_cyc_o), 64'h0);
    tick(); settle();
    chk("wr_s_cyc", 64'(s_cyc_o), 64'h1);
    chk("wr_grant", 64'(grant_o), 64'h1);
    chk("wr_s_adr", 64'(s_adr_o), 64'h8000_0000);
    chk("wr_s_dat", 64'(s_dat_o), 64'h55);
    chk("wr_s_sel", 64'(s_sel_o), 64'hF);
    chk("wr_s_we",  64'(s_we_o),  64'h1);
    chk("wr_wait_ack", 64'(m_ack_o), 64'h0);
    tick();
    s_ack_i = 1'b1;
    settle();
    chk("wr_ack", 64'(m_ack_o), 64'h1);
    chk("wr_err", 64'(m_err_o), 64'h0);
    tick();
    s_ack_i = 1'b0;
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    m_we_i  = 2'b00;
    settle();
    chk("wr_drop_cyc", 64'(s_cyc_o), 64'h0);
    chk("wr_drop_grant", 64'(grant_o), 64'h1);
    tick(); settle();
    chk("wr_idle_grant", 64'(grant_o), 64'h0);

    // Both masters, three single reads each; master 0 went last, so master 1 leads
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_a = (k % 2 == 0) ? 32'h0000_1000 : 32'h8000_0000;
      tick(); settle();
      chk("rr_grant", 64'(grant_o), 64'(exp_g));
      chk("rr_adr",   64'(s_adr_o), 64'(exp_a));
      s_ack_i = 1'b1;
      settle();
      chk("rr_ack", 64'(m_ack_o), 64'(exp_g));
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = ~exp_g;
      m_stb_i = ~exp_g;
      settle();
      chk("rr_drop_cyc", 64'(s_cyc_o), 64'h0);
      tick(); settle();
      chk("rr_dead_grant", 64'(grant_o), 64'h0);
      chk("rr_dead_cyc",   64'(s_cyc_o), 64'h0);
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
    end
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;

    // Master 1 burst of 4 reads while master 0 waits
    tick();
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick(); settle();
    chk("bu_grant", 64'(grant_o), 64'h2);
    chk("bu_we",    64'(s_we_o),  64'h0);
    chk("bu_adr",   64'(s_adr_o), 64'h1000);
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1;
      s_dat_i = 32'hD0 + 32'(b);
      settle();
      chk("bu_ack",   64'(m_ack_o), 64'h2);
      chk("bu_dat",   64'(m_dat_o), 64'hD0 + 64'(b));
      chk("bu_hold",  64'(grant_o), 64'h2);
      tick();
    end
    s_ack_i = 1'b0;
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    settle();
    chk("bu_end_grant", 64'(grant_o), 64'h2);
    chk("bu_end_ack",   64'(m_ack_o), 64'h0);
    chk("bu_end_cyc",   64'(s_cyc_o), 64'h0);
    tick(); settle();
    chk("bu_dead_grant", 64'(grant_o), 64'h0);
    tick(); settle();
    chk("bu_m0_grant", 64'(grant_o), 64'h1);
    chk("bu_m0_adr",   64'(s_adr_o), 64'h8000_0000);

    // ACK and ERR together: ERR wins
    s_ack_i = 1'b1;
    s_err_i = 1'b1;
    settle();
    chk("ae_err", 64'(m_err_o), 64'h1);
    chk("ae_ack", 64'(m_ack_o), 64'h0);
    tick();
    s_ack_i = 1'b0;
    settle();
    chk("e_only_err", 64'(m_err_o), 64'h1);
    tick();
    s_err_i = 1'b0;
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    tick(); settle();
    chk("ae_idle", 64'(grant_o), 64'h0);

    // Stalled slave, master 1 (last grant was master 0)
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick(); settle();
    chk("st_grant", 64'(grant_o), 64'h2);
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      chk("wd_pre_err", 64'(m_err_o), 64'h0);
      chk("wd_pre_cyc", 64'(s_cyc_o), 64'h1);
      tick(); settle();
    end
    chk("wd_err_pulse", 64'(m_err_o), 64'h2);
    chk("wd_no_ack",    64'(m_ack_o), 64'h0);
    tick(); settle();
    chk("wd_abort_cyc",   64'(s_cyc_o), 64'h0);
    chk("wd_abort_err",   64'(m_err_o), 64'h0);
    chk("wd_abort_grant", 64'(grant_o), 64'h2);
    tick(); settle();
    chk("wd_abort_hold", 64'(s_cyc_o), 64'h0);
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    tick(); settle();
    chk("wd_idle", 64'(grant_o), 64'h0);
    // Response on the limit cycle beats the watchdog
    m_cyc_i = 2'b10;
    m_stb_i = 2'b10;
    tick(); settle();
    for (int c = 1; c < 8; c++) begin
      tick(); settle();
    end
    s_ack_i = 1'b1;
    settle();
    chk("wd_race_ack", 64'(m_ack_o), 64'h2);
    chk("wd_race_err", 64'(m_err_o), 64'h0);
    tick();
    s_ack_i = 1'b0;
    settle();
    chk("wd_race_cyc", 64'(s_cyc_o), 64'h1);
    chk("wd_race_noerr", 64'(m_err_o), 64'h0);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
    end
    settle();
    chk("st_cyc",   64'(s_cyc_o), 64'h1);
    chk("st_err",   64'(m_err_o), 64'h0);
    chk("st_grant_hold", 64'(grant_o), 64'h2);
`endif
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    tick(); settle();
    chk("st_idle", 64'(grant_o), 64'h0);

    // Asynchronous reset in BUSY; master 0 granted so the pointer would favour master 1
    m_cyc_i = 2'b01;
    m_stb_i = 2'b01;
    tick(); settle();
    chk("ar_grant", 64'(grant_o), 64'h1);
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    s_ack_i = 1'b1;
    RST     = 1'b1;
    #1;
    chk("ar_grant0", 64'(grant_o), 64'h0);
    chk("ar_cyc0",   64'(s_cyc_o), 64'h0);
    chk("ar_ack0",   64'(m_ack_o), 64'h0);
    tick();
    s_ack_i = 1'b0;
    RST     = 1'b0;
    settle();
    chk("ar_idle", 64'(grant_o), 64'h0);
    tick(); settle();
    chk("ar_first_m0", 64'(grant_o), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
